pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
Central sequencing controller for the 5-stage RV32I pipeline, covering IF, ID, EX, MEM and WB.
- Consumes the decoded control bits already carried in each pipeline register: reg_write, Load, Store, next_sel, Branch.
- Generates per-stage stall and flush controls, plus EX operand forwarding selects.
- Owns the data-memory request/ready handshake, using a wait-state FSM with a timeout trap.

Parameters:
MEM_TIMEOUT, 16, maximum MEM_WAIT cycles before the controller traps (minimum 2).
CNT_W, 32, width of the performance counters (optional feature only).

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
id_rs1  in  5  rs1 of the instruction in ID
id_rs2  in  5  rs2 of the instruction in ID
id_rs1_used  in  1  ID instruction reads rs1
id_rs2_used  in  1  ID instruction reads rs2
ex_rs1  in  5  rs1 of the instruction in EX
ex_rs2  in  5  rs2 of the instruction in EX
ex_rd  in  5  destination register in EX
ex_load  in  1  EX instruction is a load
ex_redirect  in  1  taken branch, jal or jalr resolved in EX
mem_rd  in  5  destination register in MEM
mem_reg_write  in  1  MEM instruction writes the register file
mem_load  in  1  MEM instruction is a load
mem_store  in  1  MEM instruction is a store
wb_rd  in  5  destination register in WB
wb_reg_write  in  1  WB instruction writes the register file
dmem_ready  in  1  data memory completes the access this cycle
dmem_req  out  1  data memory access request
pc_stall  out  1  hold the PC
if_id_stall  out  1  hold IF/ID
id_ex_stall  out  1  hold ID/EX
ex_mem_stall  out  1  hold EX/MEM
if_id_flush  out  1  load a bubble into IF/ID
id_ex_flush  out  1  load a bubble into ID/EX
mem_wb_flush  out  1  load a bubble into MEM/WB
fwd_a  out  2  EX operand A select: 00 register file, 01 EX/MEM result, 10 WB data
fwd_b  out  2  EX operand B select, same encoding as fwd_a
trap  out  1  sticky memory-timeout error

Behaviour:
- FSM states: RUN, MEM_WAIT, ERR. Reset puts the FSM in RUN, clears the wait counter to 0 and clears trap to 0.
- All stall, flush and forwarding outputs are combinational from the current state and the inputs.

Forwarding (all states):
- fwd_a = 01 when mem_reg_write, !mem_load, mem_rd != 0 and mem_rd == ex_rs1.
- Otherwise fwd_a = 10 when wb_reg_write, wb_rd != 0 and wb_rd == ex_rs1.
- Otherwise fwd_a = 00.
- fwd_b is identical, using ex_rs2.
- The MEM-stage source takes priority over WB. x0 is never forwarded.

Definitions:
- load_use = ex_load & ex_rd != 0 & ((id_rs1_used & id_rs1 == ex_rd) | (id_rs2_used & id_rs2 == ex_rd)).
- mem_acc = mem_load | mem_store.
- dmem_req = mem_acc in RUN and MEM_WAIT; 0 in ERR.

RUN:
- If mem_acc & !dmem_ready:
  - Assert pc_stall, if_id_stall, id_ex_stall, ex_mem_stall and mem_wb_flush.
  - Next state is MEM_WAIT; the wait counter loads 1.
  - Load-use and redirect handling are suppressed this cycle.
- Else if ex_redirect: assert if_id_flush and id_ex_flush. No stall.
- Else if load_use: assert pc_stall, if_id_stall and id_ex_flush, giving exactly a 1-cycle bubble.
- Precedence: memory stall > redirect > load-use.

MEM_WAIT:
- Stalls and mem_wb_flush are asserted exactly as on RUN entry; dmem_req is held at 1.
- On dmem_ready:
  - Release all stalls and deassert mem_wb_flush this cycle.
  - Evaluate ex_redirect and load_use as in RUN, same cycle.
  - Next state is RUN; the counter clears.
- Else if counter == MEM_TIMEOUT-1: next state is ERR.
- Else the counter increments by 1.
- A zero-wait access (dmem_ready high in its first RUN cycle) never enters MEM_WAIT.

ERR:
- All four stalls asserted, mem_wb_flush = 1, trap = 1, dmem_req = 0.
- Exit only via rst.

Reset mid-operation: asynchronous return to RUN with the counter at 0, independent of clk.

Optional Feature:
Macro: HAZ_PERF_CNT_EN.

When defined, adds three CNT_W-bit output ports:
- perf_stall_cyc: cycles with pc_stall = 1.
- perf_flush_cnt: cycles with if_id_flush = 1.
- perf_mem_wait: cycles spent in MEM_WAIT.

Counter rules:
- Each counter resets to 0.
- Each counter saturates at all-ones and does not wrap.

When the macro is undefined, these ports and their logic are absent; all other behaviour is identical.

Test Plan:
- Forwarding priority: ex_rs1=5, mem_rd=5 with mem_reg_write=1, wb_rd=5 with wb_reg_write=1 -> fwd_a=01. Then mem_rd=0 -> fwd_a=10. Then ex_rs1=0 -> fwd_a=00.
- Load-use: ex_load=1, ex_rd=3, id_rs2=3, id_rs2_used=1, no memory access -> pc_stall=1, if_id_stall=1, id_ex_flush=1 for exactly 1 cycle. With ex_rd=0 -> no stall.
- Redirect over load-use: ex_redirect=1 with the load_use condition true -> if_id_flush=1, id_ex_flush=1, pc_stall=0.
- Memory wait: mem_load=1 with dmem_ready low for 3 cycles then high -> 3 cycles of all stalls plus mem_wb_flush, dmem_req=1 throughout. On the 4th cycle stalls drop, FSM returns to RUN, trap=0.
- Timeout: mem_store=1, dmem_ready held 0, MEM_TIMEOUT=16 -> ERR entered after 16 stalled cycles, trap=1 sticky, dmem_req=0. Asserting rst=0 -> trap=0, FSM in RUN.
- Reset mid-wait: rst asserted during MEM_WAIT between clock edges -> all stalls deassert immediately. With HAZ_PERF_CNT_EN defined, all perf counters read 0.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall, flush and forwarding control for a 5-stage RV32I pipeline, with a data-memory wait FSM and timeout trap.
// Optional performance counters are enabled by defining HAZ_PERF_CNT_EN.
module pipeline_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16
`ifdef HAZ_PERF_CNT_EN
  , parameter int CNT_W = 32
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rs1,
  input  logic [4:0] ex_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_load,
  input  logic       ex_redirect,
  input  logic [4:0] mem_rd,
  input  logic       mem_reg_write,
  input  logic       mem_load,
  input  logic       mem_store,
  input  logic [4:0] wb_rd,
  input  logic       wb_reg_write,
  input  logic       dmem_ready,
  output logic       dmem_req,
  output logic       pc_stall,
  output logic       if_id_stall,
  output logic       id_ex_stall,
  output logic       ex_mem_stall,
  output logic       if_id_flush,
  output logic       id_ex_flush,
  output logic       mem_wb_flush,
  output logic [1:0] fwd_a,
  output logic [1:0] fwd_b,
  output logic       trap
`ifdef HAZ_PERF_CNT_EN
  , output logic [CNT_W-1:0] perf_stall_cyc,
  output logic [CNT_W-1:0] perf_flush_cnt,
  output logic [CNT_W-1:0] perf_mem_wait
`endif
);

  localparam logic [1:0] S_RUN      = 2'd0;
  localparam logic [1:0] S_MEM_WAIT = 2'd1;
  localparam logic [1:0] S_ERR      = 2'd2;
  localparam int         WCW        = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  logic [1:0]     state_reg, state_next;
  logic [WCW-1:0] wait_cnt_reg, wait_cnt_next;
  logic           mem_acc;
  logic           load_use;
  logic           mem_hold;
  logic           ctrl_ok;

  assign mem_acc  = mem_load | mem_store;
  assign load_use = ex_load && (ex_rd != 5'd0) &&
                    ((id_rs1_used && (id_rs1 == ex_rd)) || (id_rs2_used && (id_rs2 == ex_rd)));

  // MEM-stage result wins over WB; loads in MEM have no data yet, and x0 is never forwarded.
  assign fwd_a = (mem_reg_write && !mem_load && (mem_rd != 5'd0) && (mem_rd == ex_rs1)) ? 2'b01 :
                 (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs1))                   ? 2'b10 : 2'b00;
  assign fwd_b = (mem_reg_write && !mem_load && (mem_rd != 5'd0) && (mem_rd == ex_rs2)) ? 2'b01 :
                 (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == ex_rs2))                   ? 2'b10 : 2'b00;

  assign trap = (state_reg == S_ERR);

  always_comb begin
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    dmem_req      = 1'b0;
    mem_hold      = 1'b0;
    ctrl_ok       = 1'b0;
    case (state_reg)
      S_RUN: begin
        dmem_req = mem_acc;
        if (mem_acc && !dmem_ready) begin
          mem_hold      = 1'b1;
          state_next    = S_MEM_WAIT;
          wait_cnt_next = WCW'(1);
        end else begin
          ctrl_ok = 1'b1;
        end
      end
      S_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ready) begin
          ctrl_ok       = 1'b1;
          state_next    = S_RUN;
          wait_cnt_next = '0;
        end else begin
          mem_hold = 1'b1;
          if (wait_cnt_reg == WAIT_LAST) begin
            state_next = S_ERR;
          end else begin
            wait_cnt_next = wait_cnt_reg + WCW'(1);
          end
        end
      end
      S_ERR: begin
        mem_hold = 1'b1;
      end
      default: begin
        state_next    = S_RUN;
        wait_cnt_next = '0;
      end
    endcase
  end

  // Memory hold freezes everything upstream of MEM and bubbles WB; otherwise redirect beats load-use.
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    id_ex_stall  = 1'b0;
    ex_mem_stall = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_flush  = 1'b0;
    mem_wb_flush = 1'b0;
    if (mem_hold) begin
      pc_stall     = 1'b1;
      if_id_stall  = 1'b1;
      id_ex_stall  = 1'b1;
      ex_mem_stall = 1'b1;
      mem_wb_flush = 1'b1;
    end else if (ctrl_ok) begin
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (load_use) begin
        pc_stall    = 1'b1;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= S_RUN;
      wait_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
    end
  end

`ifdef HAZ_PERF_CNT_EN
  logic [2:0]       perf_inc;
  logic [CNT_W-1:0] perf_cnt_reg [3];

  assign perf_inc[0] = pc_stall;
  assign perf_inc[1] = if_id_flush;
  assign perf_inc[2] = (state_reg == S_MEM_WAIT);

  // Saturating counters: they stick at all-ones rather than wrap.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_perf
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          perf_cnt_reg[gi] <= '0;
        end else if (perf_inc[gi] && (perf_cnt_reg[gi] != {CNT_W{1'b1}})) begin
          perf_cnt_reg[gi] <= perf_cnt_reg[gi] + CNT_W'(1);
        end
      end
    end
  endgenerate

  assign perf_stall_cyc = perf_cnt_reg[0];
  assign perf_flush_cnt = perf_cnt_reg[1];
  assign perf_mem_wait  = perf_cnt_reg[2];
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed test-plan steps followed by random cycles
// checked against a cycle-level model (outstanding wait length + trapped flag).
module tb_pipeline_hazard_ctrl;
  localparam int MEM_TIMEOUT = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [4:0] id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic       id_rs1_used, id_rs2_used, ex_load, ex_redirect;
  logic       mem_reg_write, mem_load, mem_store, wb_reg_write, dmem_ready;
  logic       dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall;
  logic       if_id_flush, id_ex_flush, mem_wb_flush, trap;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] perf_stall_cyc, perf_flush_cnt, perf_mem_wait;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // model state: length of the current unanswered access, and whether the timeout fired
  int wait_len = 0;
  bit trapped  = 0;
  int m_stall = 0, m_flush = 0, m_wait = 0;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_load(ex_load), .ex_redirect(ex_redirect),
    .mem_rd(mem_rd), .mem_reg_write(mem_reg_write), .mem_load(mem_load), .mem_store(mem_store),
    .wb_rd(wb_rd), .wb_reg_write(wb_reg_write), .dmem_ready(dmem_ready),
    .dmem_req(dmem_req), .pc_stall(pc_stall), .if_id_stall(if_id_stall), .id_ex_stall(id_ex_stall),
    .ex_mem_stall(ex_mem_stall), .if_id_flush(if_id_flush), .id_ex_flush(id_ex_flush),
    .mem_wb_flush(mem_wb_flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .trap(trap)
`ifdef HAZ_PERF_CNT_EN
    , .perf_stall_cyc(perf_stall_cyc), .perf_flush_cnt(perf_flush_cnt), .perf_mem_wait(perf_mem_wait)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  function automatic logic [1:0] fwd_ref(input logic [4:0] rs);
    if (mem_reg_write && !mem_load && mem_rd != 0 && mem_rd == rs) return 2'b01;
    if (wb_reg_write && wb_rd != 0 && wb_rd == rs) return 2'b10;
    return 2'b00;
  endfunction

  // Expected {dmem_req, pc/if_id/id_ex/ex_mem stall, if_id/id_ex/mem_wb flush, fwd_a, fwd_b, trap}
  function automatic logic [12:0] expect_out();
    bit lu, pending, hold, req;
    logic [6:0] ctl;
    lu = ex_load && ex_rd != 0 && ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
    if (trapped) return {1'b0, 7'b1111_001, fwd_ref(ex_rs1), fwd_ref(ex_rs2), 1'b1};
    pending = (wait_len > 0) || mem_load || mem_store;
    hold    = pending && !dmem_ready;
    req     = (wait_len > 0) ? 1'b1 : (mem_load || mem_store);
    if (hold)             ctl = 7'b1111_001;
    else if (ex_redirect) ctl = 7'b0000_110;
    else if (lu)          ctl = 7'b1100_010;
    else                  ctl = 7'b0000_000;
    return {req, ctl, fwd_ref(ex_rs1), fwd_ref(ex_rs2), 1'b0};
  endfunction

  function automatic logic [12:0] observed();
    return {dmem_req, pc_stall, if_id_stall, id_ex_stall, ex_mem_stall,
            if_id_flush, id_ex_flush, mem_wb_flush, fwd_a, fwd_b, trap};
  endfunction

  task automatic quiet();
    {id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd} = '0;
    {id_rs1_used, id_rs2_used, ex_load, ex_redirect} = '0;
    {mem_reg_write, mem_load, mem_store, wb_reg_write, dmem_ready} = '0;
  endtask

  // Called at posedge+1 with inputs already driven; checks, clocks, advances the model.
  task automatic step(input string tag);
    logic [12:0] e;
    #1;
    e = expect_out();
    $display("cyc=%0d %s out=%b exp=%b", cyc, tag, observed(), e);
    chk(tag, 32'(observed()), 32'(e));
`ifdef HAZ_PERF_CNT_EN
    chk({tag, "_pstall"}, perf_stall_cyc, m_stall);
    chk({tag, "_pflush"}, perf_flush_cnt, m_flush);
    chk({tag, "_pwait"},  perf_mem_wait,  m_wait);
`endif
    @(posedge clk);
    cyc++;
    m_stall += int'(e[11]);
    m_flush += int'(e[7]);
    m_wait  += int'(!trapped && wait_len > 0);
    if (!trapped) begin
      if (e[11] && (wait_len > 0 || mem_load || mem_store)) begin
        wait_len++;
        if (wait_len == MEM_TIMEOUT) trapped = 1;
      end else begin
        wait_len = 0;
      end
    end
    #1;
  endtask

  task automatic reset_model();
    wait_len = 0; trapped = 0; m_stall = 0; m_flush = 0; m_wait = 0;
  endtask

  task automatic release_rst();
    @(negedge clk) rst = 1'b1;
    @(posedge clk) #1;
  endtask

  initial begin
    quiet();
    rst = 1'b0;
    reset_model();
    #12;
    chk("reset_out", 32'(observed()), 32'd0);
    release_rst();

    // forwarding priority
    ex_rs1 = 5; mem_rd = 5; mem_reg_write = 1; wb_rd = 5; wb_reg_write = 1;
    #1 chk("fwd_mem_prio", fwd_a, 2'b01); step("fwd_mem");
    mem_rd = 0;
    #1 chk("fwd_wb", fwd_a, 2'b10); step("fwd_wb");
    ex_rs1 = 0;
    #1 chk("fwd_x0", fwd_a, 2'b00); step("fwd_x0");
    ex_rs2 = 5; mem_rd = 5; mem_load = 1; dmem_ready = 1;
    #1 chk("fwd_b_load_skip", fwd_b, 2'b10); step("fwd_b_load");
    quiet();

    // load-use: one bubble, then the load has moved on
    ex_load = 1; ex_rd = 3; id_rs2 = 3; id_rs2_used = 1;
    #1 chk("lu_stall", {pc_stall, if_id_stall, id_ex_flush}, 3'b111); step("lu");
    ex_load = 0;
    #1 chk("lu_one_cycle", pc_stall, 1'b0); step("lu_after");
    ex_load = 1; ex_rd = 0; id_rs2 = 0;
    #1 chk("lu_x0", pc_stall, 1'b0); step("lu_x0");
    ex_rd = 3; id_rs2 = 3; ex_redirect = 1;
    #1 chk("redir_over_lu", {if_id_flush, id_ex_flush, pc_stall}, 3'b110); step("redir");
    quiet();

    // memory wait of 3 cycles, then ready
    mem_load = 1; dmem_ready = 0;
    repeat (3) begin
      #1 chk("memwait_hold", {dmem_req, ex_mem_stall, mem_wb_flush}, 3'b111); step("memwait");
    end
    dmem_ready = 1;
    #1 chk("memwait_release", {pc_stall, ex_mem_stall, mem_wb_flush, trap}, 4'b0000); step("memdone");
    quiet();

    // timeout into ERR, sticky until reset
    mem_store = 1;
    repeat (MEM_TIMEOUT) step("timeout");
    #1 chk("err_trap", {trap, dmem_req, pc_stall}, 3'b101); step("err");
    quiet(); dmem_ready = 1;
    step("err_sticky");
    step("err_sticky");
    rst = 1'b0; reset_model(); quiet();
    #1 chk("err_reset_trap", trap, 1'b0);
    release_rst();

    // asynchronous reset in the middle of a wait
    mem_load = 1;
    step("midwait");
    step("midwait");
    #3 rst = 1'b0; mem_load = 0; reset_model();
    #1 chk("midrst_stalls", {pc_stall, if_id_stall, id_ex_stall, ex_mem_stall, mem_wb_flush}, 5'd0);
`ifdef HAZ_PERF_CNT_EN
    chk("midrst_perf", perf_stall_cyc | perf_flush_cnt | perf_mem_wait, 32'd0);
`endif
    release_rst();

    // random traffic against the model
    for (int i = 0; i < 400; i++) begin
      id_rs1 = 5'($urandom_range(0, 3)); id_rs2 = 5'($urandom_range(0, 3));
      ex_rs1 = 5'($urandom_range(0, 3)); ex_rs2 = 5'($urandom_range(0, 3));
      ex_rd  = 5'($urandom_range(0, 3)); mem_rd = 5'($urandom_range(0, 3));
      wb_rd  = 5'($urandom_range(0, 3));
      {id_rs1_used, id_rs2_used, mem_reg_write, wb_reg_write} = 4'($urandom);
      ex_load     = ($urandom_range(0, 2) == 0);
      ex_redirect = ($urandom_range(0, 4) == 0);
      if (wait_len == 0) begin
        mem_load  = ($urandom_range(0, 3) == 0);
        mem_store = !mem_load && ($urandom_range(0, 4) == 0);
      end
      dmem_ready = ($urandom_range(0, 2) != 0);
      step("rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog cyc=%0d observed=timeout expected=finish", cyc);
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end
endmodule
